// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: 3-bit FSM state
// encoding and state-name constants used by the controller and the bench.
package mult_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_SIGN  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/mult_shift_add_ctrl.sv
// Sequencer for the shift-and-add multiplier.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_init          start request (honoured only in IDLE)
//   i_ack           consumer has read the result (honoured only in DONE)
//   i_mplr_zero     multiplier register is zero
//   i_mplr_lsb      multiplier register bit 0
//   o_ld_c          load operands / clear accumulator (combinational)
//   o_add_c         accumulate multiplicand
//   o_sh_c          shift multiplicand left, multiplier right
//   o_fix_c         apply sign and load result
//   o_done, o_busy  state decodes
module mult_shift_add_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
)(
  input  logic clk,
  input  logic rst,
  input  logic i_init,
  input  logic i_ack,
  input  logic i_mplr_zero,
  input  logic i_mplr_lsb,
  output logic o_ld_c,
  output logic o_add_c,
  output logic o_sh_c,
  output logic o_fix_c,
  output logic o_done,
  output logic o_busy
);

  localparam int unsigned CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam bit HOLD_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             w_hold_exp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Cycles spent in DONE; held at zero elsewhere so it is clear on DONE entry
  always_ff @(posedge clk) begin
    if (rst)                     r_hold_cnt <= '0;
    else if (r_state != ST_DONE) r_hold_cnt <= '0;
    else                         r_hold_cnt <= r_hold_cnt + CNT_W'(1);
  end

  assign w_hold_exp = HOLD_EN && (r_hold_cnt == HOLD_LAST);

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    o_ld_c      = 1'b0;
    o_add_c     = 1'b0;
    o_sh_c      = 1'b0;
    o_fix_c     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_init) begin
          o_ld_c      = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (i_mplr_zero)     w_state_nxt = ST_SIGN;
        else if (i_mplr_lsb) w_state_nxt = ST_ADD;
        else                 w_state_nxt = ST_SHIFT;
      end
      ST_ADD: begin
        o_add_c     = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_sh_c      = 1'b1;
        w_state_nxt = ST_CHECK;
      end
      ST_SIGN: begin
        o_fix_c     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // ack and hold expiry together still make one move to IDLE
        if (i_ack || w_hold_exp) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_done = (r_state == ST_DONE);
  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/mult_shift_add.sv
// Sequential shift-and-add multiplier with optional signed operation and a
// done/ack handshake with an optional hold timeout.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init            start request, sampled in IDLE with op_a/op_b/signed_mode
//   op_a, op_b      multiplicand, multiplier (WIDTH bits)
//   signed_mode     treat operands as two's complement
//   ack             consumer has read result
//   busy            high whenever not IDLE
//   done            result valid (DONE state)
//   result          2*WIDTH-bit product, held until the next product
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          SIGNED_EN = 1'b1,
  parameter int unsigned HOLD_MAX  = 15
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               signed_mode,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [PW-1:0]    r_acc;
  logic             r_neg;

  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_acc_neg;
  logic             w_ld;
  logic             w_add;
  logic             w_sh;
  logic             w_fix;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
  assign w_sgn     = signed_mode & SIGNED_EN;
  assign w_a_neg   = w_sgn & op_a[WIDTH-1];
  assign w_b_neg   = w_sgn & op_b[WIDTH-1];
  assign w_abs_a   = w_a_neg ? (~op_a + WIDTH'(1)) : op_a;
  assign w_abs_b   = w_b_neg ? (~op_b + WIDTH'(1)) : op_b;
  assign w_acc_neg = ~r_acc + PW'(1);

  mult_shift_add_ctrl #(
    .HOLD_MAX (HOLD_MAX)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_init      (init),
    .i_ack       (ack),
    .i_mplr_zero (r_mplr == '0),
    .i_mplr_lsb  (r_mplr[0]),
    .o_ld_c      (w_ld),
    .o_add_c     (w_add),
    .o_sh_c      (w_sh),
    .o_fix_c     (w_fix),
    .o_done      (done),
    .o_busy      (busy)
  );

  // Datapath; strobes are mutually exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      result  <= '0;
    end else begin
      if (w_ld) begin
        r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
        r_mplr  <= w_abs_b;
        r_acc   <= '0;
        r_neg   <= w_a_neg ^ w_b_neg;
      end
      if (w_add) r_acc <= r_acc + r_mcand;
      if (w_sh) begin
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
      end
      if (w_fix) result <= r_neg ? w_acc_neg : r_acc;
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// Self-checking bench for mult_shift_add (WIDTH=8). A HOLD_MAX=15 instance
// carries most scenarios; a HOLD_MAX=0 instance checks indefinite hold.
module tb_mult_shift_add;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        init, ack, signed_mode;
  logic [7:0]  op_a, op_b;
  logic        busy, done;
  logic [15:0] result;
  logic        init0, ack0;
  logic        busy0, done0;
  logic [15:0] result0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_shift_add #(.WIDTH(8), .SIGNED_EN(1'b1), .HOLD_MAX(15)) dut (
    .clk(clk), .rst(rst), .init(init), .op_a(op_a), .op_b(op_b),
    .signed_mode(signed_mode), .ack(ack), .busy(busy), .done(done),
    .result(result)
  );

  mult_shift_add #(.WIDTH(8), .SIGNED_EN(1'b1), .HOLD_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .init(init0), .op_a(op_a), .op_b(op_b),
    .signed_mode(signed_mode), .ack(ack0), .busy(busy0), .done(done0),
    .result(result0)
  );

  // Reference product from plain integer arithmetic
  function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b,
                                              input logic sm);
    int sa, sb, p;
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    p = sa * sb;
    return p[15:0];
  endfunction

  // Reference latency: 2*bitlength(|b|) + popcount(|b|) + 2
  function automatic int ref_latency(input logic [7:0] b, input logic sm);
    int m, len, pop;
    m = sm ? int'($signed(b)) : int'(b);
    if (m < 0) m = -m;
    len = 0;
    pop = 0;
    while (m != 0) begin
      len++;
      pop += m % 2;
      m = m / 2;
    end
    return 2 * len + pop + 2;
  endfunction

  // Start one operation on dut and count edges until done (-1 on timeout)
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       output int lat);
    op_a = a; op_b = b; signed_mode = sm; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); signed_mode = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic ack_and_check(input string name);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: busy=%b done=%b, required busy=0 done=0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; ack = 1'b0; init0 = 1'b0; ack0 = 1'b0;
    op_a = '0; op_b = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h, required 0 0 0000", busy, done, result);
    end
    checks++;
    if (dut.u_ctrl.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dut.u_ctrl.r_state, ST_IDLE);
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs0: busy=%b done=%b result=%h, required 0 0 0000", busy0, done0, result0);
    end
  endtask

  task automatic test_directed();
    logic [7:0]  ta [7] = '{8'h03, 8'h80, 8'hFD, 8'hFF, 8'hFF, 8'h80, 8'h80};
    logic [7:0]  tb [7] = '{8'h05, 8'hFF, 8'h05, 8'h00, 8'hFF, 8'h80, 8'hFF};
    logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] tr [7] = '{16'h000F, 16'h0080, 16'hFFF1, 16'h0000, 16'hFE01, 16'h4000, 16'h7F80};
    int          tl [7] = '{10, 5, 10, 2, 26, 19, 26};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], ts[i], lat);
      checks++;
      if (lat !== tl[i]) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d edges, required %0d", i, lat, tl[i]);
      end
      checks++;
      if (result !== tr[i]) begin
        errors++;
        $display("FAIL directed%0d_result: got %h, required %h", i, result, tr[i]);
      end
      ack_and_check($sformatf("directed%0d", i));
    end
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic        sm;
    logic [15:0] exp;
    int lat, w;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      exp = ref_product(a, b, sm);
      do_op(a, b, sm, lat);
      checks++;
      if (lat !== ref_latency(b, sm)) begin
        errors++;
        $display("FAIL rand%0d_latency: a=%h b=%h sm=%b got %0d, required %0d",
                 i, a, b, sm, lat, ref_latency(b, sm));
      end
      w = $urandom_range(0, 5);
      repeat (w) @(posedge clk);
      #1;
      checks++;
      if (result !== exp || done !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_result: a=%h b=%h sm=%b got %h done=%b, required %h done=1",
                 i, a, b, sm, result, done, exp);
      end
      ack_and_check($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_hold();
    int lat, n;
    do_op(8'd11, 8'd13, 1'b0, lat);
    n = 0;
    while (done && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_timeout: done cycles=%0d busy=%b, required 15 and busy=0", n, busy);
    end
    checks++;
    if (result !== 16'd143) begin
      errors++;
      $display("FAIL hold_result: got %h, required %h", result, 16'd143);
    end
  endtask

  task automatic test_hold_forever();
    int lat, n;
    op_a = 8'hFA; op_b = 8'h07; signed_mode = 1'b1; init0 = 1'b1;
    @(posedge clk); #1;
    init0 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done0) begin lat = i; break; end
    end
    checks++;
    if (lat !== ref_latency(8'h07, 1'b1)) begin
      errors++;
      $display("FAIL hold0_latency: got %0d, required %0d", lat, ref_latency(8'h07, 1'b1));
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (done0) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 100 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL hold0_wait: done high %0d of 100 cycles, now done=%b, required 100 and 1", n, done0);
    end
    ack0 = 1'b1;
    @(posedge clk); #1;
    ack0 = 1'b0;
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || result0 !== 16'hFFD6) begin
      errors++;
      $display("FAIL hold0_ack: done=%b busy=%b result=%h, required 0 0 ffd6", done0, busy0, result0);
    end
  endtask

  task automatic test_init_ignored();
    int lat;
    op_a = 8'd5; op_b = 8'd6; signed_mode = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    op_a = 8'd9; op_b = 8'd9;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 4) init = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat !== 10 || result !== 16'd30) begin
      errors++;
      $display("FAIL busy_init: latency=%0d result=%h, required 10 and 001e", lat, result);
    end
    init = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    init = 1'b0; ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done_init_ack: busy=%b, required 0", busy);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || result !== 16'd30) begin
      errors++;
      $display("FAIL idle_hold: busy=%b result=%h, required 0 and 001e", busy, result);
    end
  endtask

  task automatic test_ack_outside();
    int lat;
    ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: busy=%b done=%b, required 0 0", busy, done);
    end
    op_a = 8'd7; op_b = 8'd3; signed_mode = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 4) ack = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat !== 8 || result !== 16'd21) begin
      errors++;
      $display("FAIL busy_ack: latency=%0d result=%h, required 8 and 0015", lat, result);
    end
    ack_and_check("busy_ack");
  endtask

  task automatic test_rst_mid();
    int lat, seen;
    op_a = 8'hFF; op_b = 8'hFF; signed_mode = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 16'h0 || done !== 1'b0 || seen !== 0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b result=%h early_done=%0d, required 0 0 0000 0",
               busy, done, result, seen);
    end
    do_op(8'd7, 8'd9, 1'b0, lat);
    checks++;
    if (lat !== 12 || result !== 16'h003F) begin
      errors++;
      $display("FAIL rst_restart: latency=%0d result=%h, required 12 and 003f", lat, result);
    end
    ack_and_check("rst_restart");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_hold_forever();
    test_init_ignored();
    test_ack_outside();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mult_shift_add.md
MULT_SHIFT_ADD -- requirements
Module: mult_shift_add

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, minimum 2.
REQ-002 Parameter SIGNED_EN, default 1: 1 enables the signed mode; 0 forces unsigned operation.
REQ-003 Parameter HOLD_MAX, default 15: maximum DONE cycles without ack; 0 means wait for ack indefinitely.
REQ-004 Port list SHALL be:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- init  in  1  start request; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand; sampled with init.
- op_b  in  WIDTH  multiplier; sampled with init.
- signed_mode  in  1  two's-complement operands; sampled with init.
- ack  in  1  consumer has read the result.
- busy  out  1  high in every state except IDLE.
- done  out  1  result valid; high only in DONE.
- result  out  2*WIDTH  product.

Function
REQ-005 The FSM SHALL have states IDLE, CHECK, ADD, SHIFT, SIGN and DONE; done and busy SHALL be decoded from the state register.
REQ-006 In IDLE with init=1 the block SHALL do all of the following:
- latch |op_a| into a 2*WIDTH multiplicand register and |op_b| into a WIDTH multiplier register;
- record neg = signed_mode & SIGNED_EN & (op_a[MSB] ^ op_b[MSB]);
- clear the accumulator;
- go to CHECK.
REQ-007 Absolute values SHALL be taken only in signed mode; |-2^(WIDTH-1)| SHALL be 2^(WIDTH-1) as an unsigned WIDTH-bit value.
REQ-008 CHECK transitions:
- multiplier==0 -> SIGN;
- else multiplier LSB=1 -> ADD;
- else -> SHIFT.
REQ-009 ADD SHALL add the multiplicand to the accumulator modulo 2^(2*WIDTH), then go to SHIFT.
REQ-010 SHIFT SHALL shift the multiplicand left by 1 and the multiplier right by 1 (logical), then go to CHECK.
REQ-011 SIGN SHALL load result with the two's-complement negation of the accumulator when neg=1, else with the accumulator, then go to DONE.
REQ-012 Latency: done SHALL rise exactly 2*L+P+2 rising edges after the edge that sampled init, where L is the bit length of |op_b| and P its popcount; the maximum is 3*WIDTH+2.
REQ-013 In DONE, ack=1 SHALL return the FSM to IDLE on the next edge.
REQ-014 If HOLD_MAX>0 and ack stays low, the FSM SHALL return to IDLE after exactly HOLD_MAX cycles in DONE.
REQ-015 The hold counter SHALL clear on DONE entry and be wide enough for HOLD_MAX.
REQ-016 init SHALL be ignored in every state except IDLE, including when asserted together with ack in DONE; it is not queued.
REQ-017 result SHALL hold its value from SIGN until the next SIGN and SHALL NOT change in IDLE.
REQ-018 If ack and a HOLD_MAX expiry fall in the same cycle, the transition SHALL be a single move to IDLE.
REQ-019 ack outside DONE SHALL have no effect.

Reset
REQ-020 rst=1 at a clock edge SHALL force state IDLE and clear result, the accumulator, the operand registers, neg and the hold counter; busy and done then read 0.
REQ-021 rst asserted mid-operation SHALL abort the operation with no done pulse; a later init SHALL start cleanly.
REQ-022 No initial blocks SHALL be used to give state values; rst is the only initialisation mechanism.

Structure
REQ-023 Package mult_pkg SHALL hold the state encoding (3-bit) and the state-name constants used by the bench.
REQ-024 The FSM SHALL be a sub-module mult_shift_add_ctrl producing ld, add, sh, fix and done strobes; the datapath SHALL live in the top module.
REQ-025 The design SHALL use one clock domain with no latches and only synchronous reset.

Verification (WIDTH=8 unless stated)
REQ-026 Unsigned op_a=3, op_b=5 -> result=0x000F; done rises 10 edges after init; ack then drops busy on the next edge.
REQ-027 Signed op_a=0x80 (-128), op_b=0xFF (-1) -> result=0x0080; op_a=0xFD, op_b=0x05 -> result=0xFFF1.
REQ-028 Unsigned op_b=0, op_a=0xFF -> result=0x0000 with done at 2 edges; op_a=op_b=0xFF -> 0xFE01 at 26 edges.
REQ-029 HOLD_MAX=15 with ack held low -> done high exactly 15 cycles; with HOLD_MAX=0, done stays high 100 cycles, until ack.
REQ-030 rst pulsed in cycle 4 of 0xFF*0xFF -> busy=0 and result=0 next cycle; a new init of 7*9 -> 0x003F.
